// File: rtl/duart_bus_controller.sv
// ----------------------------------------------------------------------------
// duart_bus_controller
//
// Host-bus cycle sequencer for the DUART register file. Synchronizes the
// asynchronous chip-select and interrupt-acknowledge inputs, latches the
// register index and direction at cycle start, and issues exactly one
// single-cycle read or write strobe per bus cycle. After WAIT_CYCLES it
// asserts DTACK_N and holds it until the host releases the cycle. A
// one-cycle RECOVER state follows every cycle, so a new cycle can never
// start from a stale synchronizer value.
//
// Parameters
//   WAIT_CYCLES : cycles between the strobe cycle and DTACK_N (0..15)
//   IACK_REG    : register index read during an interrupt-acknowledge cycle
//
// Ports
//   CLK      in   system clock, rising edge
//   RESET    in   synchronous active-high reset
//   CS_N     in   host chip select, active low, asynchronous
//   IACK_N   in   host interrupt acknowledge, active low, asynchronous
//   RW       in   direction (1 = read, 0 = write), sampled at cycle start
//   RS[3:0]  in   register select, sampled at cycle start
//   RD_STB   out  one-hot read strobe (registered)
//   WR_STB   out  one-hot write strobe (registered)
//   DOE      out  data-bus output enable during read acknowledge
//   DTACK_N  out  data transfer acknowledge, active low
//   IACK_CYC out  high in the strobe cycle of an interrupt-acknowledge cycle
// ----------------------------------------------------------------------------
module duart_bus_controller #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [3:0]  IACK_REG    = 4'hC
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CS_N,
   input  logic        IACK_N,
   input  logic        RW,
   input  logic [3:0]  RS,
   output logic [15:0] RD_STB,
   output logic [15:0] WR_STB,
   output logic        DOE,
   output logic        DTACK_N,
   output logic        IACK_CYC
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_STROBE,
      ST_WAIT,
      ST_ACK,
      ST_RECOVER
   } state_t;

   // Counter load value: WAIT is entered with WAIT_CYCLES-1 and leaves when
   // the counter reads zero, giving exactly WAIT_CYCLES cycles in WAIT.
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   state_t      state_q, state_d;

   logic        cs_m_q, cs_s_q;
   logic        iack_m_q, iack_s_q;

   logic [3:0]  idx_q, idx_d;
   logic        read_q, read_d;
   logic        iack_q, iack_d;
   logic [3:0]  cnt_q, cnt_d;

   logic [15:0] rd_stb_q, rd_stb_d;
   logic [15:0] wr_stb_q, wr_stb_d;
   logic        doe_q, doe_d;
   logic        dtack_n_q, dtack_n_d;
   logic        iack_cyc_q, iack_cyc_d;

   logic        req_released;

   // Two-flop synchronizers, idle (high) out of reset.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cs_m_q   <= 1'b1;
         cs_s_q   <= 1'b1;
         iack_m_q <= 1'b1;
         iack_s_q <= 1'b1;
      end else begin
         cs_m_q   <= CS_N;
         cs_s_q   <= cs_m_q;
         iack_m_q <= IACK_N;
         iack_s_q <= iack_m_q;
      end
   end

   // The cycle ends on the input that started it, not on whichever is low.
   always_comb begin
      req_released = iack_q ? iack_s_q : cs_s_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         read_q     <= 1'b0;
         iack_q     <= 1'b0;
         cnt_q      <= '0;
         rd_stb_q   <= '0;
         wr_stb_q   <= '0;
         doe_q      <= 1'b0;
         dtack_n_q  <= 1'b1;
         iack_cyc_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         read_q     <= read_d;
         iack_q     <= iack_d;
         cnt_q      <= cnt_d;
         rd_stb_q   <= rd_stb_d;
         wr_stb_q   <= wr_stb_d;
         doe_q      <= doe_d;
         dtack_n_q  <= dtack_n_d;
         iack_cyc_q <= iack_cyc_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      read_d  = read_q;
      iack_d  = iack_q;
      cnt_d   = cnt_q;

      unique case (state_q)
         ST_IDLE: begin
            // Host access has priority over interrupt acknowledge.
            if (!cs_s_q) begin
               state_d = ST_STROBE;
               idx_d   = RS;
               read_d  = RW;
               iack_d  = 1'b0;
            end else if (!iack_s_q) begin
               state_d = ST_STROBE;
               idx_d   = IACK_REG;
               read_d  = 1'b1;
               iack_d  = 1'b1;
            end
         end

         ST_STROBE: begin
            if (req_released) begin
               state_d = ST_RECOVER;
            end else if (WAIT_CYCLES > 0) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
            end else begin
               state_d = ST_ACK;
            end
         end

         ST_WAIT: begin
            // Abort takes precedence over completing the wait.
            if (req_released) begin
               state_d = ST_RECOVER;
            end else if (cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end

         ST_ACK: begin
            if (req_released) begin
               state_d = ST_RECOVER;
            end
         end

         ST_RECOVER: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered, so each output
   // is a pure function of the current state with no input-to-output path.
   always_comb begin
      rd_stb_d   = '0;
      wr_stb_d   = '0;
      iack_cyc_d = 1'b0;
      doe_d      = 1'b0;
      dtack_n_d  = 1'b1;

      if (state_d == ST_STROBE) begin
         if (read_d) begin
            rd_stb_d = 16'h0001 << idx_d;
         end else begin
            wr_stb_d = 16'h0001 << idx_d;
         end
         iack_cyc_d = iack_d;
      end

      if (state_d == ST_ACK) begin
         dtack_n_d = 1'b0;
         doe_d     = read_d;
      end
   end

   assign RD_STB   = rd_stb_q;
   assign WR_STB   = wr_stb_q;
   assign DOE      = doe_q;
   assign DTACK_N  = dtack_n_q;
   assign IACK_CYC = iack_cyc_q;

endmodule
